// File: rtl/col_load_sequencer_pkg.sv
// Shared constants and state encoding for the column-load sequencer.
// Sizes the fetch, load-tail and drain phases of one tile.
package col_load_sequencer_pkg;

  localparam int NCOL      = 4;
  localparam int LOAD_LAT  = 2;
  localparam int DRAIN_LEN = NCOL + 3;
  localparam int BURST_LEN = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_LOAD_TAIL = 3'd2;
  localparam state_t ST_DRAIN     = 3'd3;
  localparam state_t ST_FINISH    = 3'd4;

endpackage

// File: rtl/col_load_sequencer_en_skew_line.sv
// Shift register that delays an injected pulse by one extra cycle per column.
// Used both for the one-hot load-strobe walk and for the skewed shift enables.
module en_skew_line #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inject,
  output logic [N-1:0] stages
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], inject};
    end
  end

endmodule

// File: rtl/col_load_sequencer.sv
// Fetches four column words per tile from SRAM, loads each column buffer,
// then issues skewed shift-enable bursts; repeats for a programmed tile count.
module col_load_sequencer
  import col_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [7:0]        TileCnt,
  output logic              MemRdEn,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [31:0]       MemRData,
  output logic [31:0]       IWord,
  output logic [NCOL-1:0]   WriteEN,
  output logic [NCOL-1:0]   ENDown,
  output logic              Busy,
  output logic              Done
);

  state_t            state;
  logic [2:0]        cnt;
  logic [7:0]        tile;
  logic [7:0]        tiles_q;
  logic [ADDR_W-1:0] base_q;
  logic              rd_d1;
  logic              first_d1;
  logic              drain_inj;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tile    <= '0;
      tiles_q <= '0;
      base_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            base_q  <= BaseAddr;
            tiles_q <= TileCnt;
            tile    <= '0;
            cnt     <= '0;
            state   <= (TileCnt == 8'd0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (cnt == 3'(NCOL - 1)) begin
            cnt   <= '0;
            state <= ST_LOAD_TAIL;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_LOAD_TAIL: begin
          if (cnt == 3'(LOAD_LAT - 1)) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt == 3'(DRAIN_LEN - 1)) begin
            cnt <= '0;
            if ({1'b0, tile} + 9'd1 < {1'b0, tiles_q}) begin
              tile  <= tile + 8'd1;
              state <= ST_FETCH;
            end else begin
              state <= ST_FINISH;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign MemRdEn = (state == ST_FETCH);
  assign MemAddr = MemRdEn ? base_q + ADDR_W'({tile, 2'b00}) + ADDR_W'(cnt) : '0;
  assign Busy    = (state == ST_FETCH) || (state == ST_LOAD_TAIL) || (state == ST_DRAIN);
  assign Done    = (state == ST_FINISH);

  // The enable burst starts one cycle early because the skew line registers its input.
  assign drain_inj = ((state == ST_LOAD_TAIL) && (cnt == 3'(LOAD_LAT - 1))) ||
                     ((state == ST_DRAIN) && (cnt < 3'(BURST_LEN - 1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_d1    <= 1'b0;
      first_d1 <= 1'b0;
      IWord    <= '0;
    end else begin
      rd_d1    <= MemRdEn;
      first_d1 <= MemRdEn && (cnt == 3'd0);
      if (rd_d1) begin
        IWord <= MemRData;
      end
    end
  end

  en_skew_line #(.N(NCOL)) u_write_walk (
    .CLK    (CLK),
    .RST    (RST),
    .inject (first_d1),
    .stages (WriteEN)
  );

  en_skew_line #(.N(NCOL)) u_drain_skew (
    .CLK    (CLK),
    .RST    (RST),
    .inject (drain_inj),
    .stages (ENDown)
  );

endmodule

// File: doc/col_load_sequencer.md
# col_load_sequencer

Upstream controller for the four column input buffers of the MAC array. On a start command it fetches 32-bit column words from a synchronous-read SRAM and loads each column buffer in turn. It then issues skewed 4-cycle shift-enable bursts so the diagonal data wavefront enters the array. It repeats this for a programmable number of tiles and signals completion.

## Interface
- NCOL, 4: number of column buffers driven; fixed at 4 in this revision
- ADDR_W, 10: SRAM word-address width
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- Start  in  1  start request; sampled only in IDLE
- BaseAddr  in  ADDR_W  first word address; captured on accepted Start
- TileCnt  in  8  tiles to process; captured on accepted Start
- MemRdEn  out  1  SRAM read strobe
- MemAddr  out  ADDR_W  SRAM read address
- MemRData  in  32  SRAM read data, valid the cycle after MemRdEn
- IWord  out  32  shared load word to all column buffers, byte [31:24] first
- WriteEN  out  NCOL  per-column load strobe, at most one bit high
- ENDown  out  NCOL  per-column shift enable
- Busy  out  1  high from the cycle after an accepted Start until Done
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, LOAD_TAIL, DRAIN, FINISH.
- IDLE: Start=1 latches BaseAddr, TileCnt and clears the tile index t, then goes to FETCH.
- If TileCnt=0, go directly to FINISH with no SRAM access.
- FETCH runs 4 cycles, c=0..3: MemRdEn=1, MemAddr=BaseAddr+4*t+c, computed modulo 2^ADDR_W and wrapping silently.
- Data path:
  - MemRData is registered into IWord one cycle after it becomes valid.
  - WriteEN[c] is high in the same cycle IWord carries word c.
  - This gives 2 cycles from read issue to load strobe.
- LOAD_TAIL covers the 2 cycles after FETCH while the last words are still in flight.
- DRAIN runs 7 cycles, d=0..6: ENDown[c]=1 when c ≤ d ≤ c+3.
- After DRAIN:
  - If t+1 < TileCnt: increment t and return to FETCH.
  - Otherwise go to FINISH.
- FINISH lasts 1 cycle: Done=1, Busy=0, then IDLE.
- WriteEN and ENDown are never high for the same column in the same cycle. Load and drain of a tile never overlap.
- Start outside IDLE is ignored. Start in the FINISH cycle is also ignored.
- IWord holds its last value when WriteEN=0. IWord is 0 after reset.

## Timing
- Cycle 0 is the cycle Start is sampled in IDLE. Busy=1 from cycle 1.
- MemRdEn at cycles 1–4; WriteEN[c] at cycle 3+c.
- ENDown[c] at cycles 7+c..10+c; ENDown[3] last at cycle 13.
- Each tile takes 13 cycles: 4 FETCH + 2 LOAD_TAIL + 7 DRAIN. Tile t+1 starts FETCH at cycle 14.
- Done is at cycle 1+13·TileCnt; for TileCnt=0, Done is at cycle 1.
- Reset values: MemRdEn=0, MemAddr=0, IWord=0, WriteEN=0, ENDown=0, Busy=0, Done=0, state IDLE.
- RST mid-operation:
  - The next cycle shows all outputs at reset values.
  - Any in-flight read data is discarded: no WriteEN follows reset.

## Structure
- Shared package: state enum, NCOL, LOAD_LAT=2, DRAIN_LEN=NCOL+3.
- Sub-module en_skew_line: NCOL-stage shift register.
  - A 4-cycle enable pulse is injected at stage 0.
  - Each stage output drives one ENDown bit, delayed one cycle per column.
  - It is reused for the WriteEN one-hot walk, driven from a delayed MemRdEn.

## Test plan
- Reset, then Start with BaseAddr=0x010, TileCnt=1, SRAM[0x10..0x13]=0xA0A1A2A3..0xD0D1D2D3:
  - MemAddr=0x10..0x13 at cycles 1–4.
  - WriteEN=0001,0010,0100,1000 at cycles 3–6, with IWord equal to the matching word.
  - ENDown skew exactly as specified; Done at cycle 14.
- TileCnt=3, BaseAddr=0x3FC: addresses are 0x3FC–0x3FF, then wrap to 0x000–0x003 and 0x004–0x007. Done at cycle 40.
- TileCnt=0: no MemRdEn, WriteEN or ENDown activity; Done=1 at cycle 1, Busy never high.
- Start held high throughout a TileCnt=2 run: only one run occurs. The next run is accepted only on the first IDLE cycle after Done.
- RST asserted at cycle 5 of a run: cycle 6 shows all outputs 0; no WriteEN[3] follows.
- Concurrent column-buffer model: after each tile, checked by assertion, column c output bytes appear at cycles 8+c..11+c in order byte3..byte0.
